audiodac_dsdemod: RTL and testbench

AUDIODAC_DSDEMOD -- requirements
Module: audiodac_dsdemod

---
 rtl/audiodac_dsdemod.sv | 124 ++++++++++++
 tb/tb_audiodac_dsdemod.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/audiodac_dsdemod.sv
// audiodac_dsdemod: 3rd-order CIC decimator for the single-bit delta-sigma
// stream. Turns ds_i into UINT PCM at clk_i/R, R selected by osr_i
// (32/64/128/256). Mainly used to loop the DAC modulator output back.
module audiodac_dsdemod #(
  parameter int BW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          ds_i,
  input  logic [1:0]    osr_i,
  output logic [BW-1:0] data_o,
  output logic          data_vld_o
);

  localparam int IW = 25;
  localparam logic [BW-1:0] MID = BW'(1) << (BW-1);

  logic [IW-1:0] int1, int2, int3;
  logic [IW-1:0] x_d1, c1_d1, c2_d1;
  logic [IW-1:0] c1, c2, c3;
  logic [7:0]    dec_ctr;
  logic [1:0]    osr_q;
  logic [1:0]    wu_ctr;
  logic          tick;
  logic          osr_chg;
  logic [25:0]   scaled;
  logic [BW-1:0] sat;

  // Reload value R-1 for the decimation counter
  function automatic logic [7:0] rld(input logic [1:0] o);
    case (o)
      2'd0:    rld = 8'd31;
      2'd1:    rld = 8'd63;
      2'd2:    rld = 8'd127;
      default: rld = 8'd255;
    endcase
  endfunction

  // Tick decode, comb section and output scaling (c3 spans 0..R^3)
  always_comb begin
    tick    = (dec_ctr == 8'd0);
    osr_chg = tick && (osr_i != osr_q);
    c1      = int3 - x_d1;
    c2      = c1 - c1_d1;
    c3      = c2 - c2_d1;
    case (osr_q)
      2'd0:    scaled = {c3, 1'b0};
      2'd1:    scaled = {3'b0, c3[24:2]};
      2'd2:    scaled = {6'b0, c3[24:5]};
      default: scaled = {9'b0, c3[24:8]};
    endcase
    // Full-scale R^3 lands exactly on 2^16, so clamp it to all-ones
    sat = (|scaled[25:16]) ? {BW{1'b1}} : BW'(scaled[15:0]);
  end

  // Integrators run every cycle and wrap; an OSR change restarts them
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
    end else if (osr_chg) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
    end else begin
      int1 <= int1 + {{(IW-1){1'b0}}, ds_i};
      int2 <= int2 + int1;
      int3 <= int3 + int2;
    end
  end

  // Decimation counter; osr_i is only looked at when a tick happens
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dec_ctr <= 8'd0;
      osr_q   <= 2'd0;
    end else if (tick) begin
      osr_q   <= osr_i;
      dec_ctr <= rld(osr_i);
    end else begin
      dec_ctr <= dec_ctr - 8'd1;
    end
  end

  // Comb delay line, advanced on every tick that is not an OSR change
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_d1  <= '0;
      c1_d1 <= '0;
      c2_d1 <= '0;
    end else if (osr_chg) begin
      x_d1  <= '0;
      c1_d1 <= '0;
      c2_d1 <= '0;
    end else if (tick) begin
      x_d1  <= int3;
      c1_d1 <= c1;
      c2_d1 <= c2;
    end
  end

  // Output register, strobe and warm-up: the first 3 comb results are junk
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o     <= MID;
      data_vld_o <= 1'b0;
      wu_ctr     <= 2'd0;
    end else begin
      data_vld_o <= 1'b0;
      if (osr_chg) begin
        wu_ctr <= 2'd0;
      end else if (tick) begin
        if (wu_ctr == 2'd3) begin
          data_o     <= sat;
          data_vld_o <= 1'b1;
        end else begin
          wu_ctr <= wu_ctr + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audiodac_dsdemod.sv
// Bench for audiodac_dsdemod. The reference treats the decimator as an FIR
// with the boxcar^3 impulse response over the input bits seen since the last
// clear, scaled by 65536/R^3, with ticks every R cycles from an anchor edge.
module tb_audiodac_dsdemod;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ds = 1'b0;
  logic [1:0]  osr = 2'd0;
  logic [15:0] data;
  logic        data_vld;

  audiodac_dsdemod #(.BW(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ds_i(ds), .osr_i(osr),
    .data_o(data), .data_vld_o(data_vld)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int mode = 0;            // 0:zeros 1:ones 2:alternate 3:random 4:1st-order DSM of 0x4000
  logic [16:0] acc = '0;

  // ---------------- reference model ----------------
  int h_all [4][768];
  int m_osr = 0, since = 0, tcnt = 0, nsamp = 0, cyc = 0;
  int m_r, m_idx;
  bit m_tk;
  longint m_c3, m_v;
  bit hist [1024];
  logic [15:0] exp_data = 16'h8000;
  logic        exp_vld = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_osr = 0; since = 0; tcnt = 0; nsamp = 0; cyc = 0;
      exp_data = 16'h8000; exp_vld = 1'b0;
    end else begin
      m_r = 32 << m_osr;
      m_tk = ((since % m_r) == 0);
      cyc++;
      exp_vld = 1'b0;
      if (m_tk && int'(osr) != m_osr) begin
        m_osr = int'(osr); tcnt = 0; nsamp = 0; since = 1;
      end else begin
        if (m_tk) begin
          nsamp++;
          m_c3 = 0;
          for (int k = 0; k < 3*m_r-2; k++) begin
            m_idx = tcnt - 3 - k;
            if (m_idx >= 0 && hist[m_idx % 1024]) m_c3 += h_all[m_osr][k];
          end
          m_v = (m_c3 * 65536) / (longint'(m_r) * m_r * m_r);
          if (m_v > 65535) m_v = 65535;
          if (nsamp >= 4) begin
            exp_data = 16'(m_v);
            exp_vld = 1'b1;
          end
        end
        hist[tcnt % 1024] = ds;
        tcnt++;
        since++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (data !== exp_data) begin
        n_bad++;
        $display("FAIL model_data t=%0t got 0x%0h expected 0x%0h", $time, data, exp_data);
      end
      n_cmp++;
      if (data_vld !== exp_vld) begin
        n_bad++;
        $display("FAIL model_vld t=%0t got %0b expected %0b", $time, data_vld, exp_vld);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    case (mode)
      0: ds = 1'b0;
      1: ds = 1'b1;
      2: ds = ~ds;
      3: ds = 1'($urandom_range(0, 1));
      default: begin
        acc = {1'b0, acc[15:0]} + 17'h4000;
        ds = acc[16];
      end
    endcase
  endtask

  task automatic wait_strobe(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (data_vld === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_timeout: got no strobe within %0d cycles", budget);
    end
  endtask

  // One-cycle async reset pulse placed away from the clock edge
  task automatic do_reset(input logic [1:0] o, input int m);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_data", int'(data), 'h8000);
    check("rst_vld", int'(data_vld), 0);
    osr = o;
    mode = m;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, s2, s3, r, d;
    int b2 [0:511];
    // boxcar^3 impulse responses for each R
    for (int o = 0; o < 4; o++) begin
      r = 32 << o;
      for (int n = 0; n < 2*r-1; n++) b2[n] = (n < r) ? n + 1 : 2*r - 1 - n;
      for (int n = 0; n < 768; n++) begin
        h_all[o][n] = 0;
        if (n < 3*r-2)
          for (int i = 0; i < r; i++)
            if (n-i >= 0 && n-i <= 2*r-2) h_all[o][n] += b2[n-i];
      end
    end

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("init_rst_data", int'(data), 'h8000);
    check("init_rst_vld", int'(data_vld), 0);

    // all ones, R=32: 4th tick at edge 97 saturates
    osr = 2'd0; mode = 1;
    step(); step();
    rst_n = 1'b1;
    wait_strobe(200, s);
    check("ones_first_cyc", s, 97);
    check("ones_data", int'(data), 'hFFFF);
    wait_strobe(64, s2);
    check("ones_spacing", s2 - s, 32);

    // all zeros, R=256: first edge is an OSR change tick, so strobe at 1+4*256
    do_reset(2'd3, 0);
    wait_strobe(1200, s);
    check("zeros_first_cyc", s, 1025);
    check("zeros_data", int'(data), 0);
    wait_strobe(300, s2);
    check("zeros_spacing", s2 - s, 256);

    // alternating input gives exact midscale at every R
    for (int o = 0; o < 4; o++) begin
      do_reset(2'(o), 2);
      for (int k = 0; k < 5; k++) wait_strobe(5*(32 << o) + 50, s);
      check("alt_midscale", int'(data), 'h8000);
    end

    // OSR switch 1->2 mid-period, with a glitch that must be ignored
    do_reset(2'd1, 3);
    wait_strobe(600, s);
    check("osr1_first_cyc", s, 257);
    wait_strobe(100, s);
    repeat (10) step();
    osr = 2'd0;
    repeat (20) step();
    osr = 2'd2;
    wait_strobe(700, s2);
    check("osr_switch_first", s2 - s, 64 + 4*128);
    wait_strobe(200, s3);
    check("osr_switch_spacing", s3 - s2, 128);

    // reset mid-period: warm-up restarts (osr 2 vs reset osr_q 0 -> change tick)
    repeat (50) step();
    do_reset(2'd2, 3);
    wait_strobe(700, s);
    check("midrst_first_cyc", s, 513);

    // loopback through a first-order modulator of 0x4000
    for (int o = 0; o < 4; o += 3) begin
      do_reset(2'(o), 4);
      for (int k = 0; k < 5; k++) wait_strobe(5*(32 << o) + 50, s);
      d = int'(data) - 'h4000;
      check("loopback_within_2lsb", int'(d <= 2 && d >= -2), 1);
    end

    // random stream with random OSR changes and occasional resets
    mode = 3;
    for (int it = 0; it < 15000; it++) begin
      step();
      r = $urandom_range(0, 999);
      if (r < 3) osr = 2'($urandom_range(0, 3));
      else if (r == 3) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
